// File: rtl/trigger_capture_pkg.sv
// Shared types and defaults for the trigger/capture front end.
package trigger_pkg;

  localparam int DEF_DATA_W    = 12;
  localparam int DEF_N_SAMPLES = 256;

  typedef logic [DEF_DATA_W-1:0] sample_t;

  localparam logic SLOPE_RISE = 1'b0;
  localparam logic SLOPE_FALL = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    COPY  = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/trigger_capture_if.sv
// Bus between the ADC/control side and trigger_capture; o_state is a debug view of the FSM.
interface trigger_capture_if
  import trigger_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int N_SAMPLES = DEF_N_SAMPLES
);
  logic              i_enable;
  logic [DATA_W-1:0] i_sample;
  logic              i_sample_valid;
  logic [DATA_W-1:0] i_trig_level;
  logic              i_trig_slope;
  logic              i_ready;
  logic              o_read;
  logic [DATA_W-1:0] o_data_out [N_SAMPLES];
  logic              o_busy;
  logic              o_auto_trig;
  state_t            o_state;

  // read/ready: read rises once a full window sits in data_out and stays high,
  // with data_out frozen, until ready is sampled low; the block only re-arms
  // from IDLE while ready is high again.
  modport slave (
    input  i_enable, i_sample, i_sample_valid, i_trig_level, i_trig_slope, i_ready,
    output o_read, o_data_out, o_busy, o_auto_trig, o_state
  );

  modport master (
    output i_enable, i_sample, i_sample_valid, i_trig_level, i_trig_slope, i_ready,
    input  o_read, o_data_out, o_busy, o_auto_trig, o_state
  );
endinterface

// File: rtl/trigger_capture_detect.sv
// Level/slope crossing detector: compares the previous accepted sample and the current one.
module trigger_detect
  import trigger_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_update,
  input  logic [DATA_W-1:0] i_sample,
  input  logic [DATA_W-1:0] i_level,
  input  logic              i_slope,
  output logic              o_hit
);
  logic [DATA_W-1:0] r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= '0;
    end else if (i_update) begin
      r_prev <= i_sample;
    end
  end

  // Strict compare on prev so a stream sitting exactly on the level never fires.
  always_comb begin
    if (i_slope == SLOPE_FALL) begin
      o_hit = (r_prev > i_level) && (i_sample <= i_level);
    end else begin
      o_hit = (r_prev < i_level) && (i_sample >= i_level);
    end
  end
endmodule

// File: rtl/trigger_capture.sv
// Ring-buffered trigger capture: records samples, triggers on level/slope or timeout, unrolls the ring oldest-first.
module trigger_capture
  import trigger_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int N_SAMPLES    = DEF_N_SAMPLES,
  parameter int PRE_SAMPLES  = 128,
  parameter int AUTO_TIMEOUT = 4096
) (
  input logic              clk,
  input logic              rst,
  trigger_capture_if.slave bus
);
  localparam int PTR_W  = $clog2(N_SAMPLES);
  localparam int POST_N = N_SAMPLES - PRE_SAMPLES - 1;
  localparam int TMO_W  = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;

  localparam logic [PTR_W-1:0] PRE_LAST  = PTR_W'(PRE_SAMPLES - 1);
  localparam logic [PTR_W-1:0] POST_LAST = PTR_W'((POST_N > 0) ? POST_N - 1 : 0);
  localparam logic [PTR_W-1:0] N_LAST    = PTR_W'(N_SAMPLES - 1);
  localparam logic [PTR_W-1:0] PRE_OFS   = PTR_W'(PRE_SAMPLES);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'((AUTO_TIMEOUT > 0) ? AUTO_TIMEOUT - 1 : 0);

  state_t            r_state;
  state_t            w_next;
  logic              w_wr_en;
  logic              w_fire;
  logic              w_fire_auto;
  logic              w_cnt_inc;
  logic              w_hit;

  logic [DATA_W-1:0] r_ring [N_SAMPLES];
  logic [DATA_W-1:0] r_data_out [N_SAMPLES];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_cnt;
  logic [PTR_W-1:0]  r_start;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic [DATA_W-1:0] r_level;
  logic              r_slope;
  logic              r_auto;

  trigger_detect #(.DATA_W(DATA_W)) u_detect (
    .clk      (clk),
    .rst      (rst),
    .i_update (w_wr_en),
    .i_sample (bus.i_sample),
    .i_level  (r_level),
    .i_slope  (r_slope),
    .o_hit    (w_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_wr_en     = 1'b0;
    w_fire      = 1'b0;
    w_fire_auto = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_enable && bus.i_ready) w_next = PRE;
      end
      PRE: begin
        if (bus.i_sample_valid) begin
          w_wr_en = 1'b1;
          if (r_cnt == PRE_LAST) w_next = ARMED;
        end
      end
      ARMED: begin
        if (!bus.i_enable) begin
          w_next = IDLE;
        end else if (bus.i_sample_valid) begin
          w_wr_en = 1'b1;
          // A real crossing on the timeout sample takes precedence over the forced one.
          if (w_hit) begin
            w_fire = 1'b1;
          end else if ((AUTO_TIMEOUT != 0) && (r_tmo_cnt == TMO_LAST)) begin
            w_fire      = 1'b1;
            w_fire_auto = 1'b1;
          end
          if (w_fire) w_next = (POST_N == 0) ? COPY : POST;
        end
      end
      POST: begin
        if (bus.i_sample_valid) begin
          w_wr_en = 1'b1;
          if (r_cnt == POST_LAST) w_next = COPY;
        end
      end
      COPY: begin
        if (r_cnt == N_LAST) w_next = DONE;
      end
      DONE: begin
        if (!bus.i_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_cnt_inc = (((r_state == PRE) || (r_state == POST)) && w_wr_en) || (r_state == COPY);

  always_ff @(posedge clk) begin
    if (w_wr_en) r_ring[r_wr_ptr] <= bus.i_sample;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_cnt     <= '0;
      r_start   <= '0;
      r_tmo_cnt <= '0;
      r_level   <= '0;
      r_slope   <= 1'b0;
      r_auto    <= 1'b0;
      for (int i = 0; i < N_SAMPLES; i++) r_data_out[i] <= '0;
    end else begin
      // r_cnt is reused as the PRE fill, POST count and COPY index; it restarts on every state change.
      if (r_state != w_next) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (r_state == IDLE) begin
        r_tmo_cnt <= '0;
      end else if ((r_state == ARMED) && w_wr_en) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
      if ((r_state == IDLE) && (w_next == PRE)) begin
        r_level <= bus.i_trig_level;
        r_slope <= bus.i_trig_slope;
        r_auto  <= 1'b0;
      end
      if (w_fire) begin
        r_start <= r_wr_ptr - PRE_OFS;
        r_auto  <= w_fire_auto;
      end
      if (r_state == COPY) r_data_out[r_cnt] <= r_ring[r_start + r_cnt];
    end
  end

  assign bus.o_data_out  = r_data_out;
  assign bus.o_read      = (r_state == DONE);
  assign bus.o_busy      = (r_state != IDLE);
  assign bus.o_auto_trig = r_auto;
  assign bus.o_state     = r_state;
endmodule
